// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter and its ALU result buffer.
package wb_arbiter_pkg;

    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned RD_W    = 5;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_STARVE,
        WB_LSU,
        WB_FIFO,
        WB_ALU
    } wb_src_e;

    typedef struct packed {
        logic [RD_W-1:0]    rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending ALU write-backs; exposes per-entry valid/rd for the pending bitmap.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  wb_entry_t                      i_din,
    input  logic                           i_pop,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH):0]         o_count,
    output wb_entry_t                      o_head,
    output logic [DEPTH-1:0]               o_valid,
    output logic [DEPTH-1:0][RD_W-1:0]     o_rd
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so push is legal when full only alongside a pop.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] w_off;
        assign w_off      = PW'(g) - r_rd_ptr;
        assign o_valid[g] = ({1'b0, w_off} < r_count);
        assign o_rd[g]    = r_mem[g].rd;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: LSU load returns win over buffered/bypassed ALU results,
// with an age counter that forces the LSU to yield once the buffered head has waited too long.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = WB_XLEN,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [31:0]      pending
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AW = $clog2(MAX_WAIT + 1);

    logic                            w_full;
    logic                            w_empty;
    logic [CW-1:0]                   w_count;
    wb_entry_t                       w_head;
    wb_entry_t                       w_alu_entry;
    logic [FIFO_DEPTH-1:0]           w_ent_valid;
    logic [FIFO_DEPTH-1:0][RD_W-1:0] w_ent_rd;

    logic [AW-1:0]   r_age;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_starve;
    logic            w_alu_live;
    logic            w_lsu_live;
    logic            w_push;
    logic            w_pop;
    wb_src_e         w_src;
    logic [4:0]      w_wb_rd;
    logic [XLEN-1:0] w_wb_data;
    logic [31:0]     w_pending;

    assign w_starve  = (r_age == AW'(MAX_WAIT)) && !w_empty;
    assign lsu_ready = !w_starve;
    assign alu_ready = (w_count < CW'(FIFO_DEPTH));

    // x0 results complete the handshake but never occupy the write slot or the buffer.
    assign w_alu_live = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign w_lsu_live = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    assign w_alu_entry.rd   = alu_rd;
    assign w_alu_entry.data = WB_XLEN'(alu_data);

    // Priority select of the single write slot.
    always_comb begin
        w_src     = WB_NONE;
        w_pop     = 1'b0;
        w_wb_rd   = 5'd0;
        w_wb_data = '0;
        if (w_starve) begin
            w_src     = WB_STARVE;
            w_pop     = 1'b1;
            w_wb_rd   = w_head.rd;
            w_wb_data = XLEN'(w_head.data);
        end else if (w_lsu_live) begin
            w_src     = WB_LSU;
            w_wb_rd   = lsu_rd;
            w_wb_data = lsu_data;
        end else if (!w_empty) begin
            w_src     = WB_FIFO;
            w_pop     = 1'b1;
            w_wb_rd   = w_head.rd;
            w_wb_data = XLEN'(w_head.data);
        end else if (w_alu_live) begin
            w_src     = WB_ALU;
            w_wb_rd   = alu_rd;
            w_wb_data = alu_data;
        end
    end

    assign w_push = w_alu_live && (w_src != WB_ALU) && !w_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_alu_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head),
        .o_valid (w_ent_valid),
        .o_rd    (w_ent_rd)
    );

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (w_ent_valid[i]) w_pending[w_ent_rd[i]] = 1'b1;
        end
    end
    assign pending = w_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (w_empty || w_pop) begin
            r_age <= '0;
        end else if (r_age != AW'(MAX_WAIT)) begin
            r_age <= r_age + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= (w_src != WB_NONE);
            if (w_src != WB_NONE) begin
                r_wb_rd   <= w_wb_rd;
                r_wb_data <= w_wb_data;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model feeds expectations to a monitor.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXW  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pending;

    wb_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
        bit [31:0] pend;
    } exp_t;

    typedef struct {
        bit [4:0]  rd;
        bit [31:0] d;
    } ent_t;

    exp_t      exp_q[$];
    ent_t      m_q[$];
    int        m_wait;
    bit [4:0]  last_rd;
    bit [31:0] last_d;
    int        total = 0;
    int        bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        m_q.delete();
        exp_q.delete();
        m_wait  = 0;
        last_rd = '0;
        last_d  = '0;
    endfunction

    // One bus cycle: drive inputs, check the ready handshake, and predict the write-back.
    task automatic step(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                        input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
                        output bit a_acc, output bit l_acc);
        exp_t e;
        ent_t head;
        bit   starve, wrote, popped, bypassed;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        starve = (m_q.size() > 0) && (m_wait >= int'(MAXW));
        chk("lsu_ready", 32'(lsu_ready), 32'(!starve));
        chk("alu_ready", 32'(alu_ready), 32'(m_q.size() < DEPTH));
        a_acc = av && (m_q.size() < DEPTH);
        l_acc = lv && !starve;
        wrote = 0; popped = 0; bypassed = 0;
        if (starve || (!(l_acc && lrd != 0) && m_q.size() > 0)) begin
            head = m_q.pop_front();
            last_rd = head.rd; last_d = head.d;
            wrote = 1; popped = 1;
        end else if (l_acc && lrd != 0) begin
            last_rd = lrd; last_d = ld; wrote = 1;
        end else if (a_acc && ard != 0) begin
            last_rd = ard; last_d = ad; wrote = 1; bypassed = 1;
        end
        // Head-wait counter: cleared whenever the buffer was empty at the start of the cycle or drained by one.
        if (popped || (m_q.size() == 0 && !popped)) m_wait = 0;
        else if (m_wait < int'(MAXW)) m_wait++;
        if (a_acc && ard != 0 && !bypassed) m_q.push_back('{rd: ard, d: ad});
        e.v = wrote; e.rd = last_rd; e.d = last_d; e.pend = '0;
        foreach (m_q[i]) e.pend[m_q[i].rd] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        bit a, l;
        repeat (n) step(0, 0, 0, 0, 0, 0, a, l);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        model_clear();
        alu_valid = 0; lsu_valid = 0;
        @(negedge clk);
        #1;
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        #1;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_valid", 32'(wb_valid), 32'(e.v));
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", wb_data, e.d);
            chk("pending", pending, e.pend);
        end
    end

    initial begin
        bit a, l, av, lv;
        bit [4:0]  ard, lrd;
        bit [31:0] ad, ld;
        int k;
        model_clear();
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        #2;
        chk("init_wb_valid", 32'(wb_valid), 32'd0);
        chk("init_wb_rd", 32'(wb_rd), 32'd0);
        chk("init_wb_data", wb_data, 32'd0);
        chk("init_pending", pending, 32'd0);
        chk("init_alu_ready", 32'(alu_ready), 32'd1);
        chk("init_lsu_ready", 32'(lsu_ready), 32'd1);
        #20;
        rst_n = 1'b1;

        // Idle ALU stream via bypass.
        step(1, 5, 32'h11, 0, 0, 0, a, l);
        step(1, 6, 32'h22, 0, 0, 0, a, l);
        idle(2);

        // Collision: LSU wins, ALU result buffered then drained.
        step(1, 7, 32'hA, 1, 8, 32'hB, a, l);
        idle(2);

        // Back-pressure: LSU continuously busy, five ALU results offered.
        k = 0;
        for (int c = 0; c < 7; c++) begin
            step(k < 5, 5'(10 + k), 32'h100 + 32'(k), 1, 5'(20 + c), 32'h200 + 32'(c), a, l);
            if (a && k < 5) k++;
        end
        idle(6);

        // Starvation: one buffered entry against continuous load returns.
        step(1, 9, 32'h99, 1, 21, 32'h300, a, l);
        for (int c = 0; c < 12; c++) step(0, 0, 0, 1, 5'(22 + (c % 4)), 32'h310 + 32'(c), a, l);
        idle(2);

        // x0 handling.
        step(1, 0, 32'hFF, 0, 0, 0, a, l);
        step(1, 12, 32'hC, 1, 13, 32'hD, a, l);
        step(0, 0, 0, 1, 0, 32'hEE, a, l);
        idle(2);

        // Async reset with three buffered entries, then confirm no stale writes.
        for (int c = 0; c < 3; c++) step(1, 5'(14 + c), 32'h400 + 32'(c), 1, 5'(24 + c), 32'h500 + 32'(c), a, l);
        mid_reset();
        idle(4);

        // Randomised traffic with held offers until accepted.
        av = 0; lv = 0; ard = 0; lrd = 0; ad = 0; ld = 0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                mid_reset();
                av = 0; lv = 0;
            end
            if (!av && $urandom_range(0, 9) < 6) begin
                av = 1; ard = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!lv && $urandom_range(0, 9) < 7) begin
                lv = 1; lrd = 5'($urandom_range(0, 31)); ld = $urandom;
            end
            step(av, ard, ad, lv, lrd, ld, a, l);
            if (a) av = 0;
            if (l) lv = 0;
        end
        idle(8);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Arbitrates the single integer register-file write port between the in-order ALU result path and the variable-latency LSU load-return path.
- Buffers ALU results in a small FIFO whenever the port is taken by a load return.
- Its registered write-back outputs feed both the register file and the trace monitor's rdv/rd_x/rd_data inputs.
- Exports a pending-register bitmap so issue can stall on registers with buffered results.

Parameters:
XLEN, 32, data width
FIFO_DEPTH, 4, ALU result buffer entries (power of two, >=2)
MAX_WAIT, 8, cycles the FIFO head may wait before LSU is forced to yield

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle when alu_valid
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  load data offered
lsu_ready  output  1  load data accepted this cycle when lsu_valid
lsu_rd  input  5  load destination register
lsu_data  input  XLEN  load data
wb_valid  output  1  register write this cycle (registered)
wb_rd  output  5  write destination (registered)
wb_data  output  XLEN  write data (registered)
pending  output  32  bit n set while an ALU result for xn sits in the FIFO

Behaviour:
- Reset state: wb_valid=0, wb_rd=0, wb_data=0, FIFO empty, age=0, pending=0. alu_ready=1 and lsu_ready=1 while in reset.
- Reset mid-operation discards all buffered results.
- Latency: an accepted source is written to wb_* on the next rising edge. At most one write per cycle.
- Priority in each cycle, first match wins:
  1. starve (age==MAX_WAIT and FIFO non-empty): pop FIFO head to wb_*; lsu_ready=0.
  2. lsu_valid: LSU to wb_*; lsu_ready=1.
  3. FIFO non-empty: pop head to wb_*.
  4. alu_valid and FIFO empty: bypass ALU to wb_*.
- Ready signals:
  - lsu_ready=!starve.
  - alu_ready=(count<FIFO_DEPTH). When full, alu_ready=0 even if a pop occurs that cycle.
- Enqueue: the ALU result goes into the FIFO when it is accepted but not bypassed. Push and pop in the same cycle are legal when not full; count is unchanged.
- Ordering: ALU results write back strictly in acceptance order. Bypass happens only with an empty FIFO.
- The issue stage guarantees no outstanding LSU and ALU writes to the same rd. This block does not check it.
- rd==0: the handshake completes normally, but the result is dropped. It is not enqueued, wb_valid stays 0, and it does not count as a write slot, so the next priority source may write that cycle.
- Age counter:
  - 0 when the FIFO is empty or on any pop.
  - Otherwise +1 per cycle, saturating at MAX_WAIT.
  - Guarantees the FIFO head writes within MAX_WAIT+1 cycles under continuous load traffic.
- pending: combinational OR of one-hot(rd) over valid FIFO entries. Duplicate rd entries keep the bit set until the last one pops.
- wb_valid=0 in any cycle with no write; wb_rd and wb_data hold their previous values.

Decomposition:
- instruction_pkg gains:
  - wb_src_e enum {WB_NONE, WB_STARVE, WB_LSU, WB_FIFO, WB_ALU}
  - wb_entry_t packed struct {rd[4:0], data[XLEN-1:0]}
- One sub-module, wb_fifo:
  - parameterised depth, holding wb_entry_t.
  - Interfaces: push/pop, full/empty/count, head output, per-entry valid+rd vector for the pending decode.
- wb_arbiter holds the priority mux, age counter, pending decode and output registers.

Test Plan:
- Idle ALU stream: alu x5=0x11, x6=0x22 on consecutive cycles, LSU idle -> wb x5=0x11 at T+1 and x6=0x22 at T+2 via bypass; pending stays 0.
- Collision: alu x7=0xA and lsu x8=0xB in the same cycle -> wb x8=0xB at T+1 with pending[7]=1, then wb x7=0xA at T+2 with pending[7]=0.
- Back-pressure: lsu_valid held high, five ALU results offered -> alu_ready=0 after the fourth; order preserved on drain.
- Starvation: lsu_valid held high continuously with one FIFO entry -> lsu_ready=0 for exactly one cycle after 8 waiting cycles, FIFO entry written, LSU resumes the next cycle.
- x0 handling:
  - alu x0=0xFF -> no wb_valid pulse, alu_ready=1.
  - lsu x0 with a FIFO entry present -> FIFO head writes the same cycle.
- Async reset: assert rst_n=0 mid-cycle with 3 entries buffered -> wb_valid=0 and pending=0 immediately; after release there are no stale writes.
